// File: rtl/fnd_scan_controller_pkg.sv
// Shared types and constants for the 4-digit FND scan driver.
// Provides the scan state type and the leading-zero blanking helper.
package fnd_pkg;

  localparam int FND_DIGITS       = 4;
  localparam int FND_DIGIT_W      = 2;
  localparam int BCD_W            = 4;
  localparam int BCD_WORD_W       = FND_DIGITS * BCD_W;
  localparam int PRESCALE_DIV_DEF = 100_000;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // True when digit > 0 and every nibble from digit up to the MSD is zero.
  function automatic logic lz_blanked(input logic [BCD_WORD_W-1:0]  word,
                                      input logic [FND_DIGIT_W-1:0] digit);
    logic all_zero;
    all_zero = 1'b1;
    for (int d = 0; d < FND_DIGITS; d++) begin
      if (d >= int'(digit)) begin
        all_zero = all_zero & (word[d*BCD_W +: BCD_W] == '0);
      end
    end
    return (digit != '0) && all_zero;
  endfunction

endpackage

// File: rtl/fnd_scan_controller_if.sv
// Control/data bundle between the scan controller and its host/decoder side.
// The controller uses the slave modport; the host side uses master.
interface fnd_scan_if;
  import fnd_pkg::*;

  logic                   i_Enable;
  logic                   i_Load;
  logic [BCD_WORD_W-1:0]  i_Bcd;
  logic                   i_BlankLZ;
  logic                   o_En;
  logic [FND_DIGIT_W-1:0] o_DigitSelect;
  logic [BCD_W-1:0]       o_Value;
  logic                   o_FrameTick;
  logic                   o_Pending;

  modport master (
    output i_Enable, i_Load, i_Bcd, i_BlankLZ,
    input  o_En, o_DigitSelect, o_Value, o_FrameTick, o_Pending
  );

  modport slave (
    input  i_Enable, i_Load, i_Bcd, i_BlankLZ,
    output o_En, o_DigitSelect, o_Value, o_FrameTick, o_Pending
  );

endinterface

// File: rtl/fnd_scan_controller_tick_gen.sv
// Slot prescaler: counts 0..DIV-1 while enabled and pulses o_tick on the last count.
// A clear forces the count back to zero and suppresses the tick.
module fnd_tick_gen #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  assign o_tick = i_en && !i_clr && (cnt_q == CNT_MAX);

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit FND scan driver with frame-aligned double-buffered loads and leading-zero blanking.
//   state | meaning
//   IDLE  | display off, slot counters held at 0, pending word copied straight to active
//   SCAN  | stepping digit0..3 one slot each, pending word applied at frame boundary
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int PRESCALE_DIV = PRESCALE_DIV_DEF
) (
  input logic         i_clk,
  input logic         i_reset,
  fnd_scan_if.slave   bus
);

  scan_state_t            state_q, state_d;
  logic [FND_DIGIT_W-1:0] digit_q, digit_d;
  logic [BCD_WORD_W-1:0]  pend_buf_q, pend_buf_d;
  logic [BCD_WORD_W-1:0]  active_q, active_d;
  logic                   pending_q, pending_d;
  logic                   en_q, en_d;
  logic [FND_DIGIT_W-1:0] sel_q, sel_d;
  logic [BCD_W-1:0]       val_q, val_d;
  logic                   ftick_q, ftick_d;

  logic scan_run;
  logic tick;
  logic frame_bnd;
  logic xfer;

  // Dropping i_Enable stops the scan on that very edge, so gate everything with it.
  assign scan_run  = (state_q == SCAN) && bus.i_Enable;
  assign frame_bnd = tick && (digit_q == FND_DIGIT_W'(FND_DIGITS - 1));
  assign xfer      = pending_q && (frame_bnd || (state_q == IDLE));

  fnd_tick_gen #(
    .DIV (PRESCALE_DIV)
  ) u_tick_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (scan_run),
    .i_clr   (!scan_run),
    .o_tick  (tick)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      digit_q    <= '0;
      pend_buf_q <= '0;
      active_q   <= '0;
      pending_q  <= 1'b0;
      en_q       <= 1'b0;
      sel_q      <= '0;
      val_q      <= '0;
      ftick_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      pend_buf_q <= pend_buf_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      en_q       <= en_d;
      sel_q      <= sel_d;
      val_q      <= val_d;
      ftick_q    <= ftick_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    digit_d    = '0;
    pend_buf_d = pend_buf_q;
    active_d   = active_q;
    pending_d  = pending_q;
    en_d       = 1'b0;
    sel_d      = '0;
    val_d      = '0;
    ftick_d    = frame_bnd;

    case (state_q)
      IDLE:    if (bus.i_Enable)  state_d = SCAN;
      SCAN:    if (!bus.i_Enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (scan_run) begin
      digit_d = tick ? digit_q + 1'b1 : digit_q;
    end

    // A load coinciding with a transfer keeps the flag set: active takes the old word.
    if (xfer) begin
      active_d  = pend_buf_q;
      pending_d = 1'b0;
    end
    if (bus.i_Load) begin
      pend_buf_d = bus.i_Bcd;
      pending_d  = 1'b1;
    end

    if (scan_run) begin
      sel_d = digit_q;
      val_d = active_q[int'(digit_q)*BCD_W +: BCD_W];
      en_d  = !(bus.i_BlankLZ && lz_blanked(active_q, digit_q));
    end
  end

  assign bus.o_En          = en_q;
  assign bus.o_DigitSelect = sel_q;
  assign bus.o_Value       = val_q;
  assign bus.o_FrameTick   = ftick_q;
  assign bus.o_Pending     = pending_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with a 4-cycle slot prescaler.
module tb_fnd_scan_controller;
  import fnd_pkg::*;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  fnd_scan_if bus ();

  fnd_scan_controller #(
    .PRESCALE_DIV (DIV)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic en, input logic [1:0] sel,
                          input logic [3:0] val);
    check({tag, ".en"},  32'(bus.o_En),          32'(en));
    check({tag, ".sel"}, 32'(bus.o_DigitSelect), 32'(sel));
    check({tag, ".val"}, 32'(bus.o_Value),       32'(val));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_v [4];

  initial begin
    bus.i_Enable  = 1'b0;
    bus.i_Load    = 1'b0;
    bus.i_Bcd     = 16'h0000;
    bus.i_BlankLZ = 1'b0;

    // reset state
    #1 rst = 1'b1;
    #1;
    chk_slot("rst0", 1'b0, 2'd0, 4'h0);
    check("rst0.ftick", 32'(bus.o_FrameTick), 32'd0);
    check("rst0.pend",  32'(bus.o_Pending),    32'd0);
    step(1);
    rst = 1'b0;

    // load 1234 in IDLE, then scan one full frame
    bus.i_Load = 1'b1;
    bus.i_Bcd  = 16'h1234;
    step(1);
    check("idle_load.pend", 32'(bus.o_Pending), 32'd1);
    bus.i_Load = 1'b0;
    step(1);
    check("idle_xfer.pend", 32'(bus.o_Pending), 32'd0);
    bus.i_Enable = 1'b1;
    step(1);
    check("entry.en", 32'(bus.o_En), 32'd0);
    step(1);
    exp_v = '{4'h4, 4'h3, 4'h2, 4'h1};
    for (int k = 0; k < 4; k++) begin
      chk_slot($sformatf("f1.d%0d", k), 1'b1, 2'(k), exp_v[k]);
      step(3);
      check($sformatf("f1.ftick%0d", k), 32'(bus.o_FrameTick), (k == 3) ? 32'd1 : 32'd0);
      step(1);
    end
    check("f2.ftick_off", 32'(bus.o_FrameTick), 32'd0);
    chk_slot("f2.d0", 1'b1, 2'd0, 4'h4);

    // load 5678 mid-frame: current frame finishes with old word
    step(4);
    chk_slot("f2.d1", 1'b1, 2'd1, 4'h3);
    bus.i_Load = 1'b1;
    bus.i_Bcd  = 16'h5678;
    step(1);
    bus.i_Load = 1'b0;
    check("mid.pend1", 32'(bus.o_Pending), 32'd1);
    step(3);
    chk_slot("f2.d2", 1'b1, 2'd2, 4'h2);
    check("mid.pend2", 32'(bus.o_Pending), 32'd1);
    step(4);
    chk_slot("f2.d3", 1'b1, 2'd3, 4'h1);
    check("mid.pend3", 32'(bus.o_Pending), 32'd1);
    step(3);
    check("bnd.pend", 32'(bus.o_Pending),    32'd0);
    check("bnd.ftick", 32'(bus.o_FrameTick), 32'd1);
    step(1);
    exp_v = '{4'h8, 4'h7, 4'h6, 4'h5};
    chk_slot("f3.d0", 1'b1, 2'd0, exp_v[0]);
    for (int k = 1; k < 4; k++) begin
      step(4);
      chk_slot($sformatf("f3.d%0d", k), 1'b1, 2'(k), exp_v[k]);
    end

    // 1111 pending, 9999 loaded on the boundary cycle
    bus.i_Load = 1'b1;
    bus.i_Bcd  = 16'h1111;
    step(1);
    bus.i_Load = 1'b0;
    step(1);
    bus.i_Load = 1'b1;
    bus.i_Bcd  = 16'h9999;
    step(1);
    bus.i_Load = 1'b0;
    check("coll.pend",  32'(bus.o_Pending),   32'd1);
    check("coll.ftick", 32'(bus.o_FrameTick), 32'd1);
    step(1);
    chk_slot("f4.d0", 1'b1, 2'd0, 4'h1);
    for (int k = 1; k < 4; k++) begin
      step(4);
      chk_slot($sformatf("f4.d%0d", k), 1'b1, 2'(k), 4'h1);
    end
    step(3);
    check("f4.bnd.pend", 32'(bus.o_Pending), 32'd0);
    step(1);
    chk_slot("f5.d0", 1'b1, 2'd0, 4'h9);
    step(4);
    chk_slot("f5.d1", 1'b1, 2'd1, 4'h9);

    // leading-zero blanking with 0050, then 0000
    bus.i_Load    = 1'b1;
    bus.i_Bcd     = 16'h0050;
    bus.i_BlankLZ = 1'b1;
    step(1);
    bus.i_Load = 1'b0;
    step(11);
    chk_slot("lz50.d0", 1'b1, 2'd0, 4'h0);
    step(4);
    chk_slot("lz50.d1", 1'b1, 2'd1, 4'h5);
    step(4);
    chk_slot("lz50.d2", 1'b0, 2'd2, 4'h0);
    step(4);
    chk_slot("lz50.d3", 1'b0, 2'd3, 4'h0);
    bus.i_Load = 1'b1;
    bus.i_Bcd  = 16'h0000;
    step(1);
    bus.i_Load = 1'b0;
    step(3);
    chk_slot("lz0.d0", 1'b1, 2'd0, 4'h0);
    for (int k = 1; k < 4; k++) begin
      step(4);
      chk_slot($sformatf("lz0.d%0d", k), 1'b0, 2'(k), 4'h0);
    end

    // drop enable at digit2, then restart
    bus.i_BlankLZ = 1'b0;
    bus.i_Load    = 1'b1;
    bus.i_Bcd     = 16'h1234;
    step(1);
    bus.i_Load = 1'b0;
    step(3);
    chk_slot("rs.d0", 1'b1, 2'd0, 4'h4);
    step(4);
    chk_slot("rs.d1", 1'b1, 2'd1, 4'h3);
    step(4);
    chk_slot("rs.d2", 1'b1, 2'd2, 4'h2);
    bus.i_Enable = 1'b0;
    step(1);
    chk_slot("off1", 1'b0, 2'd0, 4'h0);
    step(1);
    chk_slot("off2", 1'b0, 2'd0, 4'h0);
    bus.i_Enable = 1'b1;
    step(1);
    check("reentry.en", 32'(bus.o_En), 32'd0);
    step(1);
    chk_slot("re.d0a", 1'b1, 2'd0, 4'h4);
    step(3);
    chk_slot("re.d0b", 1'b1, 2'd0, 4'h4);
    step(1);
    chk_slot("re.d1", 1'b1, 2'd1, 4'h3);

    // async reset mid-slot
    step(1);
    #2 rst = 1'b1;
    #1;
    chk_slot("arst", 1'b0, 2'd0, 4'h0);
    check("arst.ftick", 32'(bus.o_FrameTick), 32'd0);
    check("arst.pend",  32'(bus.o_Pending),    32'd0);
    #1 rst = 1'b0;
    step(1);
    check("post_rst.en", 32'(bus.o_En), 32'd0);
    step(1);
    chk_slot("post_rst.d0", 1'b1, 2'd0, 4'h0);
    check("post_rst.pend", 32'(bus.o_Pending), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
